// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared BTB geometry, counter encoding and PC field helpers
// Contents:
//   SETS, WAYS, TAGW, IDXW    array geometry (index = pc[4:2], tag = pc[31:5])
//   ST_*                      2-bit direction counter encodings
//   upd_t                     buffered resolved-branch update {pc, target, taken}
//   pc_index / pc_tag         PC field extraction
//   sat_update                saturating counter step toward the resolved direction
package btb_pkg;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int TAGW = 27;
  localparam int IDXW = 3;

  localparam logic [1:0] ST_SNT = 2'b00;
  localparam logic [1:0] ST_WNT = 2'b01;
  localparam logic [1:0] ST_WT  = 2'b10;
  localparam logic [1:0] ST_ST  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  function automatic logic [IDXW-1:0] pc_index(input logic [31:0] pc);
    return IDXW'(pc >> 2);
  endfunction

  function automatic logic [TAGW-1:0] pc_tag(input logic [31:0] pc);
    return TAGW'(pc >> 5);
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] st, input logic taken);
    if (taken) return (st == ST_ST) ? st : st + 2'd1;
    else       return (st == ST_SNT) ? st : st - 2'd1;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - small circular FIFO holding resolved-branch updates
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write request and payload (ignored when full)
//   pop              remove head entry (ignored when empty)
//   head             current head payload
//   count            registered occupancy
//   full, empty      occupancy flags derived from count
module btb_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_ctrl.sv
// rtl/btb_ctrl.sv - BTB controller: fetch lookups, update buffering, read-modify-write retire
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   f_valid, f_pc                         fetch lookup request
//   pred_vld/hit/taken/target             registered prediction, one cycle after lookup
//   u_valid, u_ready, u_pc/target/taken   resolved-branch update offer
//   rd_set, rd_valid*/tag*/target*/state*, rd_lru   array read port (data combinational)
//   wr_en/way/valid/set/tag/target/state  array entry write
//   wr_lru_en, wr_lru_val                 LRU bit write at wr_set
module btb_ctrl import btb_pkg::*; #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  input  logic [31:0]       f_pc,
  output logic              pred_vld,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              u_valid,
  output logic              u_ready,
  input  logic [31:0]       u_pc,
  input  logic [31:0]       u_target,
  input  logic              u_taken,
  output logic [IDXW-1:0]   rd_set,
  input  logic              rd_valid0,
  input  logic              rd_valid1,
  input  logic [TAGW-1:0]   rd_tag0,
  input  logic [TAGW-1:0]   rd_tag1,
  input  logic [31:0]       rd_target0,
  input  logic [31:0]       rd_target1,
  input  logic [1:0]        rd_state0,
  input  logic [1:0]        rd_state1,
  input  logic              rd_lru,
  output logic              wr_en,
  output logic              wr_way,
  output logic              wr_valid,
  output logic [IDXW-1:0]   wr_set,
  output logic [TAGW-1:0]   wr_tag,
  output logic [31:0]       wr_target,
  output logic [1:0]        wr_state,
  output logic              wr_lru_en,
  output logic              wr_lru_val
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);

  upd_t          head;
  upd_t          push_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          steal;
  logic [SW-1:0] starve_cnt;

  logic [TAGW-1:0] cmp_tag;
  logic            hit0;
  logic            hit1;
  logic            any_hit;
  logic            hit_way;
  logic [1:0]      sel_state;
  logic [31:0]     sel_target;
  logic            victim;

  assign push_data = '{pc: u_pc, target: u_target, taken: u_taken};
  assign u_ready   = (fifo_count < CW'(FIFO_DEPTH));
  assign push      = u_valid && u_ready;

  // The update path takes the read port whenever fetch does not need it, when the
  // buffer cannot accept more, or when the head has waited its full allowance.
  assign steal = !fifo_empty && (!f_valid || fifo_full || (starve_cnt == SW'(STARVE_LIM)));

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(upd_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (steal),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One tag comparator serves both the fetch lookup and the update read.
  assign rd_set     = steal ? pc_index(head.pc) : pc_index(f_pc);
  assign cmp_tag    = steal ? pc_tag(head.pc) : pc_tag(f_pc);
  assign hit0       = rd_valid0 && (rd_tag0 == cmp_tag);
  assign hit1       = rd_valid1 && (rd_tag1 == cmp_tag);
  assign any_hit    = hit0 || hit1;
  assign hit_way    = !hit0;
  assign sel_state  = hit0 ? rd_state0 : rd_state1;
  assign sel_target = hit0 ? rd_target0 : rd_target1;
  assign victim     = !rd_valid0 ? 1'b0 : (!rd_valid1 ? 1'b1 : rd_lru);

  always_comb begin
    wr_en     = 1'b0;
    wr_way    = 1'b0;
    wr_valid  = 1'b0;
    wr_tag    = cmp_tag;
    wr_target = head.target;
    wr_state  = ST_WT;
    if (steal) begin
      if (any_hit) begin
        wr_en     = 1'b1;
        wr_way    = hit_way;
        wr_valid  = 1'b1;
        wr_state  = sat_update(sel_state, head.taken);
        wr_target = head.taken ? head.target : sel_target;
      end else if (head.taken) begin
        wr_en    = 1'b1;
        wr_way   = victim;
        wr_valid = 1'b1;
      end
    end
  end

  assign wr_set     = rd_set;
  assign wr_lru_en  = wr_en;
  assign wr_lru_val = ~wr_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || steal) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A fetch that lost the port still reports a (fall-through) prediction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_vld    <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_vld    <= f_valid;
      pred_hit    <= f_valid && !steal && any_hit;
      pred_taken  <= f_valid && !steal && any_hit && sel_state[1];
      pred_target <= (f_valid && !steal && any_hit) ? sel_target : '0;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// tb/tb_btb_ctrl.sv - self-checking bench for btb_ctrl with array emulation and reference model
module tb_btb_ctrl;

  localparam int STARVE_LIM = 4;
  localparam int DEPTH      = 2;

  logic        clk;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        pred_vld, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        u_valid, u_ready, u_taken;
  logic [31:0] u_pc, u_target;
  logic [2:0]  rd_set;
  logic        rd_valid0, rd_valid1, rd_lru;
  logic [26:0] rd_tag0, rd_tag1;
  logic [31:0] rd_target0, rd_target1;
  logic [1:0]  rd_state0, rd_state1;
  logic        wr_en, wr_way, wr_valid, wr_lru_en, wr_lru_val;
  logic [2:0]  wr_set;
  logic [26:0] wr_tag;
  logic [31:0] wr_target;
  logic [1:0]  wr_state;

  btb_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc),
    .pred_vld(pred_vld), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .u_valid(u_valid), .u_ready(u_ready), .u_pc(u_pc), .u_target(u_target), .u_taken(u_taken),
    .rd_set(rd_set), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .rd_target0(rd_target0), .rd_target1(rd_target1),
    .rd_state0(rd_state0), .rd_state1(rd_state1), .rd_lru(rd_lru),
    .wr_en(wr_en), .wr_way(wr_way), .wr_valid(wr_valid), .wr_set(wr_set),
    .wr_tag(wr_tag), .wr_target(wr_target), .wr_state(wr_state),
    .wr_lru_en(wr_lru_en), .wr_lru_val(wr_lru_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array emulation driven by the DUT's write port.
  logic        arr_clr;
  logic        arr_valid  [8][2];
  logic [26:0] arr_tag    [8][2];
  logic [31:0] arr_target [8][2];
  logic [1:0]  arr_state  [8][2];
  logic        arr_lru    [8];

  assign rd_valid0  = arr_valid[rd_set][0];
  assign rd_valid1  = arr_valid[rd_set][1];
  assign rd_tag0    = arr_tag[rd_set][0];
  assign rd_tag1    = arr_tag[rd_set][1];
  assign rd_target0 = arr_target[rd_set][0];
  assign rd_target1 = arr_target[rd_set][1];
  assign rd_state0  = arr_state[rd_set][0];
  assign rd_state1  = arr_state[rd_set][1];
  assign rd_lru     = arr_lru[rd_set];

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int s = 0; s < 8; s++) begin
        arr_lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          arr_valid[s][w]  <= 1'b0;
          arr_tag[s][w]    <= '0;
          arr_target[s][w] <= '0;
          arr_state[s][w]  <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        arr_valid[wr_set][wr_way]  <= wr_valid;
        arr_tag[wr_set][wr_way]    <= wr_tag;
        arr_target[wr_set][wr_way] <= wr_target;
        arr_state[wr_set][wr_way]  <= wr_state;
      end
      if (wr_lru_en) arr_lru[wr_set] <= wr_lru_val;
    end
  end

  // Reference model: BTB contents as plain integers, update buffer as a queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } upd_s;

  upd_s        mq[$];
  int          m_starve;
  bit          m_valid  [8][2];
  logic [26:0] m_tag    [8][2];
  logic [31:0] m_tgt    [8][2];
  int          m_st     [8][2];
  int          m_lru    [8];
  bit          e_vld, e_hit, e_tk;
  logic [31:0] e_tgt;

  int   n_assert;
  int   n_fail;
  logic last_wr_en, last_wr_way, last_u_ready;
  logic [1:0] last_wr_state;
  int   steal_at;
  int   exp_nt[3] = '{1, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [31:0] pc);
    int          s = int'(pc[4:2]);
    logic [26:0] t = pc[31:5];
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic cyc(input logic fv, input logic [31:0] fpc, input logic uv,
                     input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
    int   qn, s, hw, ww, st;
    bit   steal_e, do_wr, rdy_e;
    upd_s h;
    logic [31:0] wtg;
    logic [31:0] exp_set;
    @(negedge clk);
    f_valid = fv; f_pc = fpc; u_valid = uv; u_pc = upc; u_target = utgt; u_taken = utk;
    #1;
    chk("pred_vld", 32'(pred_vld), 32'(e_vld));
    if (e_vld) begin
      chk("pred_hit", 32'(pred_hit), 32'(e_hit));
      chk("pred_taken", 32'(pred_taken), 32'(e_tk));
      chk("pred_target", pred_target, e_tgt);
    end
    qn      = mq.size();
    rdy_e   = (qn < DEPTH);
    steal_e = (qn > 0) && (!fv || qn == DEPTH || m_starve == STARVE_LIM);
    chk("u_ready", 32'(u_ready), 32'(rdy_e));
    exp_set = steal_e ? 32'(mq[0].pc[4:2]) : 32'(fpc[4:2]);
    chk("rd_set", 32'(rd_set), exp_set);
    last_wr_en = wr_en; last_wr_way = wr_way; last_wr_state = wr_state; last_u_ready = u_ready;

    do_wr = 0; ww = 0; st = 2; wtg = '0; s = 0;
    if (steal_e) begin
      h  = mq[0];
      s  = int'(h.pc[4:2]);
      hw = m_find(h.pc);
      if (hw >= 0) begin
        do_wr = 1; ww = hw; st = m_st[s][hw];
        st  = h.tk ? ((st < 3) ? st + 1 : 3) : ((st > 0) ? st - 1 : 0);
        wtg = h.tk ? h.tgt : m_tgt[s][hw];
      end else if (h.tk) begin
        do_wr = 1; st = 2; wtg = h.tgt;
        ww = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
      end
    end
    chk("wr_en", 32'(wr_en), 32'(do_wr));
    chk("wr_lru_en", 32'(wr_lru_en), 32'(do_wr));
    if (do_wr) begin
      chk("wr_set", 32'(wr_set), 32'(s));
      chk("wr_way", 32'(wr_way), 32'(ww));
      chk("wr_valid", 32'(wr_valid), 32'd1);
      chk("wr_tag", 32'(wr_tag), 32'(h.pc[31:5]));
      chk("wr_target", wr_target, wtg);
      chk("wr_state", 32'(wr_state), 32'(st));
      chk("wr_lru_val", 32'(wr_lru_val), 32'(1 - ww));
      m_valid[s][ww] = 1; m_tag[s][ww] = h.pc[31:5];
      m_tgt[s][ww] = wtg; m_st[s][ww] = st; m_lru[s] = 1 - ww;
    end

    e_vld = fv; e_hit = 0; e_tk = 0; e_tgt = '0;
    if (fv && !steal_e) begin
      hw = m_find(fpc);
      if (hw >= 0) begin
        e_hit = 1;
        e_tk  = (m_st[int'(fpc[4:2])][hw] >= 2);
        e_tgt = m_tgt[int'(fpc[4:2])][hw];
      end
    end
    if (steal_e) void'(mq.pop_front());
    if (uv && rdy_e) mq.push_back('{pc: upc, tgt: utgt, tk: utk});
    if (qn == 0 || steal_e) m_starve = 0;
    else if (m_starve < STARVE_LIM) m_starve++;
  endtask

  task automatic expect_pred(input string tag, input logic v, input logic ht,
                             input logic tk, input logic [31:0] tg);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(pred_vld), 32'(v));
    chk({tag, "_hit"}, 32'(pred_hit), 32'(ht));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({tag, "_target"}, pred_target, tg);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    cyc(1'b0, 32'h0, 1'b1, pc, tg, tk);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; m_starve = 0;
    e_vld = 0; e_hit = 0; e_tk = 0; e_tgt = '0;
    rst = 1'b1; arr_clr = 1'b1;
    f_valid = 0; f_pc = '0; u_valid = 0; u_pc = '0; u_target = '0; u_taken = 0;
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = '0; m_tgt[s][w] = '0; m_st[s][w] = 0;
      end
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_pred_vld", 32'(pred_vld), 32'd0);
    chk("rst_pred_hit", 32'(pred_hit), 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    chk("rst_u_ready", 32'(u_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_lru_en", 32'(wr_lru_en), 32'd0);
    arr_clr = 1'b0;
    rst = 1'b0;

    // Cold lookup misses.
    cyc(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("cold_u_ready", 32'(last_u_ready), 32'd1);
    expect_pred("cold", 1'b1, 1'b0, 1'b0, 32'h0);

    // Allocate, then look up two cycles after acceptance.
    upd(32'h0000_1000, 32'h0000_2000, 1'b1);
    idle();
    chk("alloc_way", 32'(last_wr_way), 32'd0);
    chk("alloc_state", 32'(last_wr_state), 32'd2);
    cyc(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_pred("alloc_lookup", 1'b1, 1'b1, 1'b1, 32'h0000_2000);

    // Not-taken training saturates at strong-NT.
    for (int k = 0; k < 3; k++) begin
      upd(32'h0000_1000, 32'h0000_3000, 1'b0);
      idle();
      chk("nt_state", 32'(last_wr_state), 32'(exp_nt[k]));
    end
    cyc(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_pred("nt_lookup", 1'b1, 1'b1, 1'b0, 32'h0000_2000);

    // Fill set 0, third distinct tag evicts the LRU way (way0, holding 0x1000).
    upd(32'h0000_1000, 32'h0000_2000, 1'b1); idle();
    upd(32'h0000_1020, 32'h0000_2020, 1'b1); idle();
    chk("fill_way1", 32'(last_wr_way), 32'd1);
    upd(32'h0000_1040, 32'h0000_2040, 1'b1); idle();
    chk("evict_way0", 32'(last_wr_way), 32'd0);
    cyc(1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 1'b0);
    expect_pred("evicted", 1'b1, 1'b0, 1'b0, 32'h0);

    // Starvation: continuous fetch, one queued update.
    cyc(1'b1, 32'h0000_1040, 1'b1, 32'h0000_1100, 32'h0000_5000, 1'b1);
    steal_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'h0000_1040, 1'b0, 32'h0, 32'h0, 1'b0);
      if (last_wr_en === 1'b1 && steal_at == 0) steal_at = i;
      if (steal_at != 0) break;
    end
    chk("starve_cycle", 32'(steal_at), 32'(STARVE_LIM + 1));
    expect_pred("stolen", 1'b1, 1'b0, 1'b0, 32'h0);

    // Two pushes under busy fetch fill the buffer and force a steal.
    cyc(1'b1, 32'h0000_1040, 1'b1, 32'h0000_1204, 32'h0000_6000, 1'b1);
    cyc(1'b1, 32'h0000_1040, 1'b1, 32'h0000_1308, 32'h0000_7000, 1'b1);
    cyc(1'b1, 32'h0000_1040, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("full_ready", 32'(last_u_ready), 32'd0);
    chk("forced_steal", 32'(last_wr_en), 32'd1);
    cyc(1'b1, 32'h0000_1040, 1'b1, 32'h0000_140c, 32'h0000_8000, 1'b1);

    // Asynchronous reset mid-stream discards buffered updates and the prediction.
    @(posedge clk);
    #2;
    rst = 1'b1; f_valid = 0; u_valid = 0;
    #1;
    chk("mid_rst_pred_vld", 32'(pred_vld), 32'd0);
    chk("mid_rst_pred_hit", 32'(pred_hit), 32'd0);
    chk("mid_rst_pred_target", pred_target, 32'd0);
    chk("mid_rst_u_ready", 32'(u_ready), 32'd1);
    mq.delete(); m_starve = 0;
    e_vld = 0; e_hit = 0; e_tk = 0; e_tgt = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc_r, upc_r;
      fpc_r = {27'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 2'b00};
      upc_r = {27'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 2'b00};
      cyc(($urandom_range(0, 3) != 0), fpc_r, ($urandom_range(0, 2) == 0), upc_r,
          ($urandom & 32'hffff_fffc), 1'($urandom_range(0, 1)));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
# btb_ctrl

Branch target buffer controller sitting between the fetch stage and the 8-set, 2-way BTB storage array. It owns the array's single read port and single write port. It turns fetch-PC lookups into registered taken/target predictions, and buffers resolved-branch updates from execute in a 2-entry FIFO. It retires each buffered update as a one-cycle read-modify-write, stealing the read port from fetch when fetch is idle or the update path is starved.

## Interface
- SETS, 8, number of sets; index = pc[4:2]
- WAYS, 2, associativity (fixed at 2)
- TAGW, 27, tag width; tag = pc[31:5]
- FIFO_DEPTH, 2, update buffer entries
- STARVE_LIM, 4, cycles a non-empty FIFO may wait before a forced steal
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- f_valid  in  1  fetch lookup request
- f_pc  in  32  fetch PC
- pred_vld  out  1  lookup was serviced last cycle
- pred_hit  out  1  serviced lookup hit a valid way
- pred_taken  out  1  hit and state[1]==1
- pred_target  out  32  hit way's target; 0 otherwise
- u_valid  in  1  resolved-branch update offered
- u_ready  out  1  FIFO not full
- u_pc, u_target  in  32  branch PC, resolved target
- u_taken  in  1  resolved direction
- rd_set  out  3  array read index
- rd_valid0/1, rd_tag0/1 [TAGW], rd_target0/1 [32], rd_state0/1 [2], rd_lru  in  array read data, combinational from rd_set
- wr_en, wr_way, wr_valid  out  1  array entry write
- wr_set  out  3  write index; also used for the LRU write
- wr_tag  out  TAGW, wr_target  out  32, wr_state  out  2  write data
- wr_lru_en, wr_lru_val  out  1  LRU write; rd_lru names the way to replace next

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Per-cycle arbitration:
  - Steal when the FIFO is non-empty and any of: f_valid==0, FIFO full, or starve count == STARVE_LIM.
  - Otherwise fetch owns the read port.
- Fetch cycle: rd_set = f_pc[4:2].
  - Hit way = valid && tag==f_pc[31:5]; way0 wins if both match.
  - Registered next cycle: pred_vld=f_valid, pred_hit, pred_taken, pred_target.
- Steal cycle: rd_set = head.pc[4:2], and the FIFO head is popped.
  - Hit, same way priority: write that way with valid=1, same tag, and saturating state (+1 if taken, −1 if not). Target is u_target if taken, else unchanged.
  - Miss and taken: allocate. Victim is the first invalid way (way0 first), else the rd_lru way. Write valid=1, tag, target, state=10.
  - Miss and not taken: no write; pop only.
  - Any write: wr_lru_en=1, wr_lru_val = ~wr_way.
- Stolen fetch cycle (f_valid==1 during a steal): next cycle pred_vld=1, pred_hit=0, pred_taken=0, pred_target=0 (fall-through).
- Starve counter:
  - Increments each cycle the FIFO is non-empty and not serviced, saturating at STARVE_LIM.
  - Clears on a steal or when the FIFO is empty.
- FIFO behaviour:
  - Push on u_valid && u_ready.
  - u_ready = count < FIFO_DEPTH from registered count; a pop does not free a slot in the same cycle.
  - Push and pop in the same cycle keep the count.
  - Pointers wrap modulo FIFO_DEPTH.
- wr_en, wr_lru_en are 0 in every non-steal cycle.

## Timing
- Lookup latency: 1 cycle (f_valid at N → pred_* valid at N+1).
- Update:
  - Accepted at edge ending N; earliest steal/write in N+1.
  - Array updated at edge ending N+1; a lookup in N+2 sees new data.
- Retire rate: one update per steal cycle. Worst-case wait for the head entry under continuous fetch is STARVE_LIM cycles.
- Reset values:
  - pred_vld, pred_hit, pred_taken, pred_target = 0.
  - FIFO empty, u_ready=1, starve count 0.
  - wr_en, wr_lru_en = 0.
- Reset mid-operation discards buffered updates and the in-flight prediction; the array clears independently.

## Structure
- Package btb_pkg: SETS, WAYS, TAGW, counter-state constants, index/tag extraction functions, saturating inc/dec function.
- Sub-module btb_upd_fifo: parameterised FIFO of {pc, target, taken} with push/pop/count/full/empty.
- Tag compare, victim select and arbitration stay in btb_ctrl.

## Test plan
- Reset, then f_valid with f_pc=0x0000_1000 → next cycle pred_vld=1, pred_hit=0, pred_target=0; u_ready=1.
- Update pc=0x1000, taken, target=0x2000 with f_valid=0 → write set 0, way0, state 10, lru=1. Lookup of 0x1000 two cycles later → hit, taken, target 0x2000.
- Three not-taken updates to the 0x1000 entry → state 10→01→00→00 (saturates). Lookup gives pred_hit=1, pred_taken=0.
- Taken updates to 0x1000, 0x1020, then 0x1040, all set 0 → ways 0, 1, then LRU victim way0 replaced (0x1000 evicted); lookup of 0x1000 misses.
- Continuous f_valid with one queued update → steal in exactly STARVE_LIM+1th cycle. That fetch gets pred_vld=1, pred_hit=0.
- Two updates pushed while fetch is busy → u_ready drops to 0 and a forced steal follows next cycle. Asserting rst mid-stream empties the FIFO and zeroes pred_*.
